// File: rtl/msftdvip_tcm_pkg.sv
// Shared types, constants and the SECDED(39,32) check-bit encoder for the CHERIoT TCM responder.
package msftdvip_tcm_pkg;

    localparam int TagBit = 32;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic        we;
        logic [32:0] rdata;
    } resp_stage_t;

    // Hsiao SECDED(39,32): each check bit is the parity of a fixed subset of the data bits.
    function automatic logic [6:0] secded_enc(input logic [31:0] data);
        logic [38:0] w;
        logic [6:0]  c;
        w    = {7'b0, data};
        c[0] = ^(w & 39'h002606BD25);
        c[1] = ^(w & 39'h00DEBA8050);
        c[2] = ^(w & 39'h00413D89AA);
        c[3] = ^(w & 39'h0031234ED1);
        c[4] = ^(w & 39'h00C2C1323B);
        c[5] = ^(w & 39'h002DCC624C);
        c[6] = ^(w & 39'h0098505586);
        return c;
    endfunction

endpackage

// File: rtl/msftdvip_tcm_intg_enc.sv
// Combinational 32-bit -> 7-bit SECDED check-bit encoder.
module msftdvip_tcm_intg_enc (
    input  logic [31:0] data,
    output logic [6:0]  intg
);
    import msftdvip_tcm_pkg::*;

    assign intg = secded_enc(data);

endmodule

// File: rtl/msftdvip_cheri_tcm_responder.sv
// CHERIoT data-bus TCM responder: grants requests, drives a single-port 33-bit SRAM, clears tags on data stores.
// Optional integrity generation/check is built when MSFTDVIP_TCM_INTG_EN is defined.
module msftdvip_cheri_tcm_responder #(
    parameter logic [31:0] AddrBase       = 32'h2004_0000,
    parameter int          DepthWords     = 16384,
    parameter int          ReadLatency    = 1,
    parameter int          MaxOutstanding = 2
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          stall_i,
    input  logic                          data_req_i,
    output logic                          data_gnt_o,
    output logic                          data_rvalid_o,
    input  logic                          data_we_i,
    input  logic                          data_is_cap_i,
    input  logic [3:0]                    data_be_i,
    input  logic [31:0]                   data_addr_i,
    input  logic [32:0]                   data_wdata_i,
    input  logic [6:0]                    data_wdata_intg_i,
    output logic [32:0]                   data_rdata_o,
    output logic [6:0]                    data_rdata_intg_o,
    output logic                          data_err_o,
    output logic                          mem_cs_o,
    output logic                          mem_we_o,
    output logic [$clog2(DepthWords)-1:0] mem_addr_o,
    output logic [32:0]                   mem_wmask_o,
    output logic [32:0]                   mem_wdata_o,
    input  logic [32:0]                   mem_rdata_i
);
    import msftdvip_tcm_pkg::*;

    localparam int          AW          = $clog2(DepthWords);
    localparam int          CW          = $clog2(MaxOutstanding + 1);
    localparam logic [32:0] WindowBytes = 33'(DepthWords) * 33'd4;

    // Handshake: a request transfers in any cycle where data_req_i and data_gnt_o are both high; the core
    // holds req and its payload until then. Each transfer yields exactly one data_rvalid_o pulse, in order,
    // ReadLatency cycles later; data_err_o and data_rdata_o are meaningful only with data_rvalid_o.

    logic [CW-1:0] outstanding_q;
    logic [CW-1:0] outstanding_eff;
    logic [31:0]   offset;
    logic          in_range;
    logic          intg_ok;
    logic          req_ok;
    logic          rvalid;

    resp_stage_t   stage_q [ReadLatency];
    resp_stage_t   new_stage;
    resp_stage_t   head;
    resp_stage_t   out_stage;

    // Addresses below the base wrap to large offsets and fall out of range.
    assign offset   = data_addr_i - AddrBase;
    assign in_range = {1'b0, offset} < WindowBytes;

`ifdef MSFTDVIP_TCM_INTG_EN
    logic [6:0] wdata_intg_calc;
    logic [6:0] rdata_intg_calc;

    msftdvip_tcm_intg_enc u_wr_enc (
        .data (data_wdata_i[31:0]),
        .intg (wdata_intg_calc)
    );

    msftdvip_tcm_intg_enc u_rd_enc (
        .data (data_rdata_o[31:0]),
        .intg (rdata_intg_calc)
    );

    assign intg_ok           = ~data_we_i | (wdata_intg_calc == data_wdata_intg_i);
    assign data_rdata_intg_o = rdata_intg_calc;
`else
    logic unused_wdata_intg;
    assign unused_wdata_intg = ^data_wdata_intg_i;
    assign intg_ok           = 1'b1;
    assign data_rdata_intg_o = '0;
`endif

    // A response leaving this cycle frees its slot, so the pipe can refill without a bubble.
    assign outstanding_eff = outstanding_q - CW'(rvalid);
    assign data_gnt_o      = data_req_i & ~stall_i & (outstanding_eff < CW'(MaxOutstanding));
    assign req_ok          = data_gnt_o & in_range & intg_ok;

    always_comb begin
        mem_cs_o    = req_ok;
        mem_we_o    = req_ok & data_we_i;
        mem_addr_o  = '0;
        mem_wmask_o = '0;
        mem_wdata_o = '0;
        if (req_ok) begin
            mem_addr_o = offset[AW+1:2];
        end
        if (req_ok && data_we_i) begin
            mem_wmask_o = {1'b1, {8{data_be_i[3]}}, {8{data_be_i[2]}},
                           {8{data_be_i[1]}}, {8{data_be_i[0]}}};
            mem_wdata_o[TagBit]   = data_is_cap_i & data_wdata_i[TagBit];
            mem_wdata_o[31:0]     = data_wdata_i[31:0];
        end
    end

    always_comb begin
        new_stage       = '0;
        new_stage.valid = data_gnt_o;
        new_stage.err   = data_gnt_o & ~(in_range & intg_ok);
        new_stage.we    = data_gnt_o & data_we_i;
    end

    // SRAM read data arrives one cycle after the access, alongside the first pipeline stage.
    always_comb begin
        head       = stage_q[0];
        head.rdata = (stage_q[0].valid & ~stage_q[0].err & ~stage_q[0].we) ? mem_rdata_i : '0;
    end

    if (ReadLatency == 1) begin : g_lat1
        assign out_stage = head;
    end else begin : g_latn
        assign out_stage = stage_q[ReadLatency-1];
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < ReadLatency; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= new_stage;
            for (int i = 1; i < ReadLatency; i++) begin
                stage_q[i] <= (i == 1) ? head : stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            outstanding_q <= '0;
        end else if (data_gnt_o && !rvalid) begin
            outstanding_q <= outstanding_q + CW'(1);
        end else if (!data_gnt_o && rvalid) begin
            outstanding_q <= outstanding_q - CW'(1);
        end
    end

    assign rvalid        = out_stage.valid;
    assign data_rvalid_o = out_stage.valid;
    assign data_err_o    = out_stage.err;
    assign data_rdata_o  = out_stage.rdata;

endmodule

// File: tb/tb_msftdvip_cheri_tcm_responder.sv
// Directed bench for the TCM responder (ReadLatency=3, MaxOutstanding=2) with a behavioural SRAM model.
module tb_msftdvip_cheri_tcm_responder;
    import msftdvip_tcm_pkg::*;

    localparam int          LAT   = 3;
    localparam int          MAXO  = 2;
    localparam int          DEPTH = 16384;
    localparam int          AW    = 14;
    localparam logic [31:0] BASE  = 32'h2004_0000;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          stall = 1'b0;
    logic          req = 1'b0;
    logic          gnt;
    logic          rvalid;
    logic          we = 1'b0;
    logic          is_cap = 1'b0;
    logic [3:0]    be = '0;
    logic [31:0]   addr = '0;
    logic [32:0]   wdata = '0;
    logic [6:0]    wdata_intg = '0;
    logic [32:0]   rdata;
    logic [6:0]    rdata_intg;
    logic          err;
    logic          mem_cs;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [32:0]   mem_wmask;
    logic [32:0]   mem_wdata;
    logic [32:0]   mem_rdata = '0;

    msftdvip_cheri_tcm_responder #(
        .AddrBase       (BASE),
        .DepthWords     (DEPTH),
        .ReadLatency    (LAT),
        .MaxOutstanding (MAXO)
    ) dut (
        .clk_i             (clk),
        .rstn_i            (rstn),
        .stall_i           (stall),
        .data_req_i        (req),
        .data_gnt_o        (gnt),
        .data_rvalid_o     (rvalid),
        .data_we_i         (we),
        .data_is_cap_i     (is_cap),
        .data_be_i         (be),
        .data_addr_i       (addr),
        .data_wdata_i      (wdata),
        .data_wdata_intg_i (wdata_intg),
        .data_rdata_o      (rdata),
        .data_rdata_intg_o (rdata_intg),
        .data_err_o        (err),
        .mem_cs_o          (mem_cs),
        .mem_we_o          (mem_we),
        .mem_addr_o        (mem_addr),
        .mem_wmask_o       (mem_wmask),
        .mem_wdata_o       (mem_wdata),
        .mem_rdata_i       (mem_rdata)
    );

    // Clock / reset and cycle count
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: bit-masked write, registered read
    logic [32:0] mem [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (mem_cs && mem_we) mem[mem_addr] <= (mem[mem_addr] & ~mem_wmask) | (mem_wdata & mem_wmask);
        if (mem_cs && !mem_we) mem_rdata <= mem[mem_addr];
    end

    int checks = 0;
    int errors = 0;
    logic [33:0] exp_q[$];
    int          gnt_cyc_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] exp_intg(input logic [31:0] d);
`ifdef MSFTDVIP_TCM_INTG_EN
        return secded_enc(d);
`else
        return 7'h00;
`endif
    endfunction

    // Scoreboard: every rvalid pops the oldest expectation
    logic [33:0] mon_e;
    int          mon_g;
    always @(negedge clk) begin
        if (!rstn) begin
            exp_q.delete();
            gnt_cyc_q.delete();
        end else if (rvalid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid actual=1 required=0 cyc=%0d", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                mon_g = gnt_cyc_q.pop_front();
                check("resp_err", 64'(err), 64'(mon_e[33]));
                check("resp_rdata", 64'(rdata), 64'(mon_e[32:0]));
                check("resp_latency", 64'(cyc - mon_g), 64'(LAT));
                check("resp_intg", 64'(rdata_intg), 64'(exp_intg(mon_e[31:0])));
            end
        end
    end

    typedef struct {
        logic        we;
        logic        cap;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [32:0] wdata;
        logic [6:0]  flip;
        logic        exp_cs;
        logic        exp_err;
        logic [32:0] exp_rdata;
    } vec_t;

    task automatic drive(input vec_t v);
        we         = v.we;
        is_cap     = v.cap;
        be         = v.be;
        addr       = v.addr;
        wdata      = v.wdata;
        wdata_intg = secded_enc(v.wdata[31:0]) ^ v.flip;
    endtask

    task automatic do_req(input vec_t v, input string name);
        int waitc;
        @(negedge clk);
        drive(v);
        req = 1'b1;
        #1;
        waitc = 0;
        while (!gnt && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (!gnt) begin
            checks++;
            errors++;
            $display("FAIL %s_gnt_timeout actual=0 required=1", name);
        end else begin
            check({name, "_cs"}, 64'(mem_cs), 64'(v.exp_cs));
            exp_q.push_back({v.exp_err, v.exp_rdata});
            gnt_cyc_q.push_back(cyc);
        end
        @(posedge clk);
        #1 req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_drain_timeout actual=%0d required=0", name, exp_q.size());
            exp_q.delete();
            gnt_cyc_q.delete();
        end
    endtask

    vec_t        vecs[13];
    vec_t        rd10;
    vec_t        rd20;
    logic [5:0]  pat;
    int          ngnt;
    int          c;

    initial begin
        //            we    cap   be       addr            wdata           flip   cs    err   rdata
        vecs[0]  = '{1'b1, 1'b1, 4'hF,    32'h2004_0010, 33'h1_DEAD_BEEF, 7'h0, 1'b1, 1'b0, 33'h0};
        vecs[1]  = '{1'b0, 1'b0, 4'hF,    32'h2004_0010, 33'h0,           7'h0, 1'b1, 1'b0, 33'h1_DEAD_BEEF};
        vecs[2]  = '{1'b1, 1'b0, 4'b0001, 32'h2004_0010, 33'h0_0000_0055, 7'h0, 1'b1, 1'b0, 33'h0};
        vecs[3]  = '{1'b0, 1'b0, 4'hF,    32'h2004_0010, 33'h0,           7'h0, 1'b1, 1'b0, 33'h0_DEAD_BE55};
        vecs[4]  = '{1'b0, 1'b0, 4'hF,    32'h2003_FFFC, 33'h0,           7'h0, 1'b0, 1'b1, 33'h0};
        vecs[5]  = '{1'b0, 1'b0, 4'hF,    32'h2005_0000, 33'h0,           7'h0, 1'b0, 1'b1, 33'h0};
        vecs[6]  = '{1'b1, 1'b1, 4'hF,    32'h2004_FFFC, 33'h1_1234_5678, 7'h0, 1'b1, 1'b0, 33'h0};
        vecs[7]  = '{1'b0, 1'b0, 4'hF,    32'h2004_FFFC, 33'h0,           7'h0, 1'b1, 1'b0, 33'h1_1234_5678};
        vecs[8]  = '{1'b1, 1'b0, 4'b0000, 32'h2004_FFFC, 33'h1_FFFF_FFFF, 7'h0, 1'b1, 1'b0, 33'h0};
        vecs[9]  = '{1'b0, 1'b0, 4'hF,    32'h2004_FFFC, 33'h0,           7'h0, 1'b1, 1'b0, 33'h0_1234_5678};
        vecs[10] = '{1'b1, 1'b1, 4'b1100, 32'h2004_0020, 33'h1_AABB_CCDD, 7'h0, 1'b1, 1'b0, 33'h0};
        vecs[11] = '{1'b0, 1'b0, 4'hF,    32'h2004_0023, 33'h0,           7'h0, 1'b1, 1'b0, 33'h1_AABB_0000};
        vecs[12] = '{1'b1, 1'b1, 4'hF,    32'h2005_0000, 33'h1_0000_0001, 7'h0, 1'b0, 1'b1, 33'h0};
        rd10     = '{1'b0, 1'b0, 4'hF,    32'h2004_0010, 33'h0,           7'h0, 1'b1, 1'b0, 33'h0_DEAD_BE55};
        rd20     = '{1'b0, 1'b0, 4'hF,    32'h2004_0020, 33'h0,           7'h0, 1'b1, 1'b0, 33'h1_AABB_0000};

        // Reset state
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({gnt, rvalid, err, rdata, rdata_intg, mem_cs, mem_we}), 64'h0);
        check("reset_mem_bus", 64'({mem_addr, mem_wmask}), 64'h0);
        rstn = 1'b1;
        @(negedge clk);
        check("post_reset_idle", 64'({gnt, rvalid, mem_cs}), 64'h0);

        // Table-driven vectors (back-to-back, ordering write->read)
        for (int i = 0; i < 13; i++) do_req(vecs[i], $sformatf("vec%0d", i));
        wait_idle("vectors");

        // Req held high for 6 reads: steady grant pattern 1,1,0,1,1,0
        @(negedge clk);
        drive(rd10);
        req  = 1'b1;
        #1;
        ngnt = 0;
        c    = 0;
        pat  = '0;
        while (ngnt < 6 && c < 40) begin
            if (gnt) begin
                exp_q.push_back({rd10.exp_err, rd10.exp_rdata});
                gnt_cyc_q.push_back(cyc);
                ngnt++;
            end
            if (c < 6) pat[5-c] = gnt;
            c++;
            @(negedge clk);
        end
        req = 1'b0;
        check("b2b_gnt_pattern", 64'(pat), 64'(6'b110110));
        check("b2b_gnt_count", 64'(ngnt), 64'd6);
        wait_idle("b2b");

        // Stall with req held: no grant, no SRAM access, grant on first cycle after release
        @(negedge clk);
        drive(rd10);
        stall = 1'b1;
        req   = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall_gnt%0d", i), 64'(gnt), 64'h0);
            check($sformatf("stall_cs%0d", i), 64'(mem_cs), 64'h0);
            @(negedge clk);
        end
        stall = 1'b0;
        #1;
        check("stall_release_gnt", 64'(gnt), 64'h1);
        if (gnt) begin
            exp_q.push_back({rd10.exp_err, rd10.exp_rdata});
            gnt_cyc_q.push_back(cyc);
        end
        @(posedge clk);
        #1 req = 1'b0;
        wait_idle("stall");

        // Reset with two reads in flight: no rvalid afterwards, then a normal request
        @(negedge clk);
        drive(rd20);
        req  = 1'b1;
        #1;
        ngnt = 0;
        c    = 0;
        while (ngnt < 2 && c < 20) begin
            if (gnt) begin
                exp_q.push_back({rd20.exp_err, rd20.exp_rdata});
                gnt_cyc_q.push_back(cyc);
                ngnt++;
            end
            c++;
            if (ngnt < 2) @(negedge clk);
        end
        @(posedge clk);
        #1 req = 1'b0;
        check("rst_inflight_gnts", 64'(ngnt), 64'd2);
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("rst_no_rvalid%0d", i), 64'(rvalid), 64'h0);
        end
        do_req(rd20, "post_rst_read");
        wait_idle("post_rst");

`ifdef MSFTDVIP_TCM_INTG_EN
        // Corrupted write integrity: suppressed write, error response, memory unchanged
        begin
            vec_t bad_wr;
            vec_t chk_rd;
            bad_wr = '{1'b1, 1'b1, 4'hF, 32'h2004_0040, 33'h1_CAFE_F00D, 7'h01, 1'b0, 1'b1, 33'h0};
            chk_rd = '{1'b0, 1'b0, 4'hF, 32'h2004_0040, 33'h0,           7'h00, 1'b1, 1'b0, 33'h0};
            do_req(bad_wr, "intg_bad_write");
            do_req(chk_rd, "intg_read_back");
            wait_idle("intg");
        end
`endif

        check("final_queue_empty", 64'(exp_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/msftdvip_cheri_tcm_responder.md
Name: msftdvip_cheri_tcm_responder

Overview:
Memory-side responder for the CHERIoT core data bus (req/gnt/rvalid protocol, 33-bit tagged words). Sits between the core wrapper's data port and a single-port 33-bit SRAM macro.
- Arbitrates grants, issues SRAM accesses and applies CHERI tag-clearing rules.
- Returns read data and errors after a fixed, parameterised latency.
- Flags out-of-range accesses as bus errors.

Parameters:
AddrBase, 32'h2004_0000, byte base address of the TCM window
DepthWords, 16384, number of 33-bit words; must be a power of 2
ReadLatency, 1, cycles from grant to rvalid; legal range 1..4
MaxOutstanding, 2, maximum granted-but-unanswered requests; legal range 1..ReadLatency+1

Ports:
clk_i  input  1  clock
rstn_i  input  1  asynchronous active-low reset
stall_i  input  1  forces data_gnt_o low (bench/backpressure hook)
data_req_i  input  1  request valid; held by the core until granted
data_gnt_o  output  1  request accepted this cycle
data_rvalid_o  output  1  response valid
data_we_i  input  1  write enable
data_is_cap_i  input  1  capability access; tag bit is significant
data_be_i  input  4  byte enables for bits 31:0
data_addr_i  input  32  byte address
data_wdata_i  input  33  write data; bit 32 is the tag
data_wdata_intg_i  input  7  write integrity bits
data_rdata_o  output  33  read data; bit 32 is the tag
data_rdata_intg_o  output  7  read integrity bits
data_err_o  output  1  error response; qualified by rvalid
mem_cs_o  output  1  SRAM chip select
mem_we_o  output  1  SRAM write enable
mem_addr_o  output  $clog2(DepthWords)  SRAM word address
mem_wmask_o  output  33  SRAM bit write mask
mem_wdata_o  output  33  SRAM write data
mem_rdata_i  input  33  SRAM read data, valid 1 cycle after cs with we=0

Behaviour:
- Reset: clk_i clock; rstn_i reset, asynchronous, active-low. All outputs reset to 0; pipeline and outstanding counter cleared.
- Reset mid-operation: in-flight responses are dropped and no rvalid is issued for them.
- Grant: data_gnt_o = data_req_i & ~stall_i & (outstanding < MaxOutstanding). This is combinational.
- Outstanding counter: +1 on grant, -1 on rvalid; unchanged when both occur in the same cycle. Never exceeds MaxOutstanding.
- Range check: in_range = (addr - AddrBase) < DepthWords*4, computed in 32-bit unsigned arithmetic, so addresses below the base wrap and fail. Word index = (addr - AddrBase) >> 2; addr[1:0] is ignored.
- SRAM drive on a granted in-range request: mem_cs_o=1 in the grant cycle, mem_we_o=data_we_i. Out-of-range requests never assert mem_cs_o.
- Write mask: bits 31:0 are byte-masked by data_be_i. Bit 32 (tag) is always written.
  - is_cap=1: tag written as data_wdata_i[32].
  - is_cap=0: tag written as 0. Any data store clears the tag, including be=4'b0000.
- Response pipeline: a shift register of ReadLatency stages, each carrying {valid, err, we}. Stage 1 captures mem_rdata_i for reads. data_rvalid_o is asserted exactly ReadLatency cycles after the grant cycle. Responses are in order.
- Read response: data_rdata_o = SRAM data. Write response: data_rdata_o = 0.
- Error response: data_err_o=1 and data_rdata_o=0, with rvalid at the normal latency.
- Ordering: a read granted in the cycle after a write to the same word returns the new data, including the updated tag.
- Back-to-back: sustains 1 request/cycle when MaxOutstanding >= ReadLatency.

Optional Feature:
MSFTDVIP_TCM_INTG_EN
- Defined:
  - data_rdata_intg_o = SECDED(39,32) encoding of data_rdata_o[31:0].
  - On a write, data_wdata_intg_i is checked against the encoding of data_wdata_i[31:0]. On mismatch the SRAM write is suppressed (mem_cs_o=0) and the response returns err=1.
- Undefined: data_rdata_intg_o = 0; no check is performed.

Decomposition:
- Package msftdvip_tcm_pkg holds:
  - resp_stage_t struct {valid, err, we, rdata[32:0]}
  - TagBit=32 constant
  - SECDED encode function for 32-bit data
- One sub-module, msftdvip_tcm_intg_enc: combinational 32->7 encoder, instantiated twice (read path and write check) only under the macro.

Test Plan:
- Reset, then write addr 0x2004_0010, be=4'hF, wdata=33'h1_DEAD_BEEF, is_cap=1; then read it -> rdata=33'h1_DEAD_BEEF, err=0, rvalid ReadLatency cycles after gnt.
- Continue with an is_cap=0 write to 0x2004_0010, be=4'b0001, wdata=0x0000_0055; read it -> rdata=33'h0_DEAD_BE55 (tag cleared, only byte 0 updated).
- Read addr 0x2003_FFFC and addr AddrBase+DepthWords*4 -> mem_cs_o never asserted; rvalid with err=1, rdata=0.
- ReadLatency=3, MaxOutstanding=2, req held high for 6 reads -> gnt pattern 1,1,0,1,1,0 in steady state; counter never exceeds 2; rvalids arrive in order.
- stall_i=1 for 5 cycles with req high -> no gnt, no mem_cs_o; gnt asserts on the first cycle after stall_i falls.
- Assert rstn_i low with 2 reads in flight -> rvalid stays 0 after release; the next request completes normally. With MSFTDVIP_TCM_INTG_EN, a write with a corrupted intg bit -> err=1 and memory contents unchanged.
